// File: rtl/axi_mem_responder_if.sv
// AXI4 read/write channel bundle between a memory master and axi_mem_responder.
// Latency: none (wires only).
// Backpressure: plain AXI valid/ready on every channel.
interface axi_mem_responder_if;
  logic        m_axi_arvalid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rready;
  logic        m_axi_awvalid;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awready;
  logic        m_axi_wvalid;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wready;
  logic        m_axi_bvalid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bready;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp
  );

  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: one read and one write burst in flight over a 64-bit word array.
// Latency: first R beat READ_LATENCY cycles after AR handshake; B one cycle after last W beat.
// Backpressure: rdata/rlast held while rready low, bvalid held until bready, one burst per direction.
// Optional macro AXI_RESP_ERR_EN: SLVERR on out-of-range beats and on wlast/beat-count mismatch.
module axi_mem_responder #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter logic [63:0] BASE_ADDR    = 64'd0,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  axi_mem_responder_if.slave axi
);
  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [15:0] WAIT_LAST = 16'(READ_LATENCY - 1);
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Storage is deliberately not reset so contents survive a bus reset.
  logic [63:0] mem_q [MEM_WORDS];

  // Word offset relative to BASE_ADDR, kept full width so out-of-range beats are detectable.
  function automatic logic [60:0] word_off(input logic [63:0] addr);
    return 61'((addr - BASE_ADDR) >> 3);
  endfunction

`ifdef AXI_RESP_ERR_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic off_oor(input logic [60:0] off);
    return |off[60:IDX_W];
  endfunction
`endif

  // Read channel state
  r_state_t    r_state_q, r_state_d;
  logic [15:0] r_cnt_q, r_cnt_d;
  logic [60:0] r_off_q, r_off_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [7:0]  r_beat_q, r_beat_d;
  logic        r_fixed_q, r_fixed_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rlast_q, rlast_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_load;
  logic [60:0] r_nxt_off;

  // Write channel state
  w_state_t    w_state_q, w_state_d;
  logic [60:0] w_off_q, w_off_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [7:0]  w_beat_q, w_beat_d;
  logic        w_fixed_q, w_fixed_d;
  logic        w_err_q, w_err_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_we;
  logic        w_beat_bad;
  logic        w_last_beat;

  // Read next-state: latch AR, wait out the latency, then stream beats loading rdata from the array.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_off_d   = r_off_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_fixed_d = r_fixed_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    r_nxt_off = r_off_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi.m_axi_arvalid && arready_q) begin
          r_state_d = R_WAIT;
          arready_d = 1'b0;
          r_off_d   = word_off(axi.m_axi_araddr);
          r_len_d   = axi.m_axi_arlen;
          r_fixed_d = (axi.m_axi_arburst == 2'b00);
          r_cnt_d   = 16'd0;
          r_beat_d  = 8'd0;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == WAIT_LAST) begin
          r_state_d = R_BURST;
          rvalid_d  = 1'b1;
          rlast_d   = (r_len_q == 8'd0);
          r_load    = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + 16'd1;
        end
      end
      R_BURST: begin
        if (axi.m_axi_rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rdata_d   = 64'd0;
            rresp_d   = RESP_OKAY;
            arready_d = 1'b1;
          end else begin
            r_nxt_off = r_fixed_q ? r_off_q : r_off_q + 61'd1;
            r_off_d   = r_nxt_off;
            r_beat_d  = r_beat_q + 8'd1;
            rlast_d   = ((r_beat_q + 8'd1) == r_len_q);
            r_load    = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Beat data is sampled at the edge it is presented, so a same-edge write is not yet visible.
    if (r_load) begin
      rdata_d = mem_q[r_nxt_off[IDX_W-1:0]];
      rresp_d = RESP_OKAY;
`ifdef AXI_RESP_ERR_EN
      if (off_oor(r_nxt_off)) begin
        rdata_d = 64'd0;
        rresp_d = RESP_SLVERR;
      end
`endif
    end
  end

  // Read state and registered R/AR outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 16'd0;
      r_off_q   <= 61'd0;
      r_len_q   <= 8'd0;
      r_beat_q  <= 8'd0;
      r_fixed_q <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 64'd0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_off_q   <= r_off_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_fixed_q <= r_fixed_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write next-state: latch AW, accept awlen+1 beats (wlast only checked for errors), then respond.
  always_comb begin
    w_state_d   = w_state_q;
    w_off_d     = w_off_q;
    w_len_d     = w_len_q;
    w_beat_d    = w_beat_q;
    w_fixed_d   = w_fixed_q;
    w_err_d     = w_err_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    w_we        = 1'b0;
    w_beat_bad  = 1'b0;
    w_last_beat = (w_beat_q == w_len_q);
    case (w_state_q)
      W_IDLE: begin
        if (axi.m_axi_awvalid && awready_q) begin
          w_state_d = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_off_d   = word_off(axi.m_axi_awaddr);
          w_len_d   = axi.m_axi_awlen;
          w_fixed_d = (axi.m_axi_awburst == 2'b00);
          w_beat_d  = 8'd0;
          w_err_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (axi.m_axi_wvalid && wready_q) begin
`ifdef AXI_RESP_ERR_EN
          w_beat_bad = off_oor(w_off_q) || (axi.m_axi_wlast != w_last_beat);
          w_we       = !off_oor(w_off_q);
`else
          w_we       = 1'b1;
`endif
          w_err_d = w_err_q | w_beat_bad;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = {w_err_d, 1'b0};
          end else begin
            w_beat_d = w_beat_q + 8'd1;
            w_off_d  = w_fixed_q ? w_off_q : w_off_q + 61'd1;
          end
        end
      end
      W_RESP: begin
        if (axi.m_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_err_d   = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write state and registered AW/W/B outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_off_q   <= 61'd0;
      w_len_q   <= 8'd0;
      w_beat_q  <= 8'd0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_off_q   <= w_off_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-masked array write for each accepted in-range beat.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (axi.m_axi_wstrb[b]) begin
          mem_q[w_off_q[IDX_W-1:0]][8*b +: 8] <= axi.m_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Beat size is fixed at 8 bytes, so size fields carry no information here.
  logic unused_sink;
  assign unused_sink = ^{axi.m_axi_arsize, axi.m_axi_awsize, axi.m_axi_wlast};

  assign axi.m_axi_arready = arready_q;
  assign axi.m_axi_rvalid  = rvalid_q;
  assign axi.m_axi_rdata   = rdata_q;
  assign axi.m_axi_rlast   = rlast_q;
  assign axi.m_axi_rresp   = rresp_q;
  assign axi.m_axi_awready = awready_q;
  assign axi.m_axi_wready  = wready_q;
  assign axi.m_axi_bvalid  = bvalid_q;
  assign axi.m_axi_bresp   = bresp_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, strobes, stalls, FIXED/WRAP, reset abort, range.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Build with AXI_RESP_ERR_EN defined to exercise the SLVERR expectations.
module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_mem_responder_if bus();

  axi_mem_responder #(
    .MEM_WORDS(4096),
    .BASE_ADDR(64'd0),
    .READ_LATENCY(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .axi(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] wbuf [16];
  logic [63:0] rexp [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input logic [1:0] exp_resp);
    int n;
    int to;
    to = 0;
    bus.m_axi_awvalid = 1'b1;
    bus.m_axi_awaddr  = addr;
    bus.m_axi_awlen   = len;
    bus.m_axi_awsize  = 3'b011;
    bus.m_axi_awburst = burst;
    n = 0;
    while (bus.m_axi_awready !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) to++;
    tick();
    bus.m_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.m_axi_wvalid = 1'b1;
      bus.m_axi_wdata  = wbuf[i];
      bus.m_axi_wstrb  = strb;
      bus.m_axi_wlast  = (i == int'(len));
      n = 0;
      while (bus.m_axi_wready !== 1'b1 && n < 100) begin tick(); n++; end
      if (n >= 100) to++;
      tick();
    end
    bus.m_axi_wvalid = 1'b0;
    bus.m_axi_wlast  = 1'b0;
    chk({tag, "_timeout"}, 64'(to), 64'd0);
    chk({tag, "_bvalid"}, 64'(bus.m_axi_bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(bus.m_axi_bresp), 64'(exp_resp));
    bus.m_axi_bready = 1'b1;
    tick();
    bus.m_axi_bready = 1'b0;
    chk({tag, "_bdone"}, 64'(bus.m_axi_bvalid), 64'd0);
  endtask

  task automatic do_read(input string tag, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle, input logic [1:0] exp_resp);
    int n;
    int beat;
    int cyc;
    bus.m_axi_arvalid = 1'b1;
    bus.m_axi_araddr  = addr;
    bus.m_axi_arlen   = len;
    bus.m_axi_arsize  = 3'b011;
    bus.m_axi_arburst = burst;
    n = 0;
    while (bus.m_axi_arready !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    bus.m_axi_arvalid = 1'b0;
    n = 0;
    while (bus.m_axi_rvalid !== 1'b1 && n < 100) begin tick(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 200) begin
      bus.m_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      chk($sformatf("%s_vld%0d", tag, beat), 64'(bus.m_axi_rvalid), 64'd1);
      chk($sformatf("%s_dat%0d", tag, beat), bus.m_axi_rdata, rexp[beat]);
      chk($sformatf("%s_lst%0d", tag, beat), 64'(bus.m_axi_rlast), 64'(beat == int'(len)));
      chk($sformatf("%s_rsp%0d", tag, beat), 64'(bus.m_axi_rresp), 64'(exp_resp));
      tick();
      if (bus.m_axi_rready) beat++;
      cyc++;
    end
    bus.m_axi_rready = 1'b0;
    chk({tag, "_beats"}, 64'(beat), 64'(int'(len) + 1));
    chk({tag, "_rvalid_end"}, 64'(bus.m_axi_rvalid), 64'd0);
    chk({tag, "_arready_end"}, 64'(bus.m_axi_arready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    bus.m_axi_arvalid = 1'b0; bus.m_axi_araddr = 64'd0; bus.m_axi_arlen = 8'd0;
    bus.m_axi_arsize = 3'b011; bus.m_axi_arburst = 2'b01; bus.m_axi_rready = 1'b0;
    bus.m_axi_awvalid = 1'b0; bus.m_axi_awaddr = 64'd0; bus.m_axi_awlen = 8'd0;
    bus.m_axi_awsize = 3'b011; bus.m_axi_awburst = 2'b01;
    bus.m_axi_wvalid = 1'b0; bus.m_axi_wdata = 64'd0; bus.m_axi_wstrb = 8'd0;
    bus.m_axi_wlast = 1'b0; bus.m_axi_bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_arready", 64'(bus.m_axi_arready), 64'd1);
    chk("rst_awready", 64'(bus.m_axi_awready), 64'd1);
    chk("rst_rvalid", 64'(bus.m_axi_rvalid), 64'd0);
    chk("rst_rdata", bus.m_axi_rdata, 64'd0);
    chk("rst_rlast", 64'(bus.m_axi_rlast), 64'd0);
    chk("rst_rresp", 64'(bus.m_axi_rresp), 64'd0);
    chk("rst_wready", 64'(bus.m_axi_wready), 64'd0);
    chk("rst_bvalid", 64'(bus.m_axi_bvalid), 64'd0);
    chk("rst_bresp", 64'(bus.m_axi_bresp), 64'd0);
    reset = 1'b1;
    tick();

    // INCR write 1..4 then read back
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    do_write("t1_wr", 64'h40, 8'd3, 2'b01, 8'hFF, 2'b00);
    for (int i = 0; i < 4; i++) rexp[i] = 64'(i + 1);
    do_read("t1_rd", 64'h40, 8'd3, 2'b01, 1'b0, 2'b00);

    // Partial strobe over an all-ones word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write("t2_fill", 64'h100, 8'd0, 2'b01, 8'hFF, 2'b00);
    wbuf[0] = 64'h1122_3344_5566_7788;
    do_write("t2_wr", 64'h100, 8'd0, 2'b01, 8'h0F, 2'b00);
    rexp[0] = 64'hFFFF_FFFF_5566_7788;
    do_read("t2_rd", 64'h100, 8'd0, 2'b01, 1'b0, 2'b00);

    // 8-beat read with rready toggling; data/rlast must hold during stalls
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h10 + 64'(i);
    do_write("t3_wr", 64'h200, 8'd7, 2'b01, 8'hFF, 2'b00);
    for (int i = 0; i < 8; i++) rexp[i] = 64'h10 + 64'(i);
    do_read("t3_rd", 64'h200, 8'd7, 2'b01, 1'b1, 2'b00);

    // WRAP behaves as INCR
    rexp[0] = 64'h10; rexp[1] = 64'h11;
    do_read("t3_wrap", 64'h200, 8'd1, 2'b10, 1'b0, 2'b00);

    // FIXED read of word 8 alongside an independent write burst
    for (int i = 0; i < 3; i++) rexp[i] = 64'd1;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h30 + 64'(i);
    fork
      do_read("t4_fixed", 64'h40, 8'd2, 2'b00, 1'b0, 2'b00);
      do_write("t4_wr", 64'h300, 8'd3, 2'b01, 8'hFF, 2'b00);
    join
    for (int i = 0; i < 4; i++) rexp[i] = 64'h30 + 64'(i);
    do_read("t4_chk", 64'h300, 8'd3, 2'b01, 1'b0, 2'b00);

    // Reset during the third beat of a burst
    bus.m_axi_arvalid = 1'b1; bus.m_axi_araddr = 64'h200;
    bus.m_axi_arlen = 8'd7; bus.m_axi_arburst = 2'b01;
    n = 0;
    while (bus.m_axi_arready !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    bus.m_axi_arvalid = 1'b0;
    chk("t5_arready_busy", 64'(bus.m_axi_arready), 64'd0);
    n = 0;
    while (bus.m_axi_rvalid !== 1'b1 && n < 100) begin tick(); n++; end
    chk("t5_lat", 64'(n), 64'd4);
    bus.m_axi_rready = 1'b1;
    tick();
    tick();
    bus.m_axi_rready = 1'b0;
    chk("t5_beat2_dat", bus.m_axi_rdata, 64'h12);
    reset = 1'b0;
    #1;
    chk("t5_rst_rvalid", 64'(bus.m_axi_rvalid), 64'd0);
    chk("t5_rst_arready", 64'(bus.m_axi_arready), 64'd1);
    chk("t5_rst_rlast", 64'(bus.m_axi_rlast), 64'd0);
    tick();
    reset = 1'b1;
    bus.m_axi_rready = 1'b1;
    tick();
    chk("t5_post_rvalid", 64'(bus.m_axi_rvalid), 64'd0);
    bus.m_axi_rready = 1'b0;
    rexp[0] = 64'h13; rexp[1] = 64'h14;
    do_read("t5_after", 64'h218, 8'd1, 2'b01, 1'b0, 2'b00);

    // One word past the top of the array
    wbuf[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    do_write("t6_w0", 64'h0, 8'd0, 2'b01, 8'hFF, 2'b00);
`ifdef AXI_RESP_ERR_EN
    rexp[0] = 64'd0;
    do_read("t6_oor_rd", 64'h8000, 8'd0, 2'b01, 1'b0, 2'b10);
    wbuf[0] = 64'hDEAD_BEEF;
    do_write("t6_oor_wr", 64'h8000, 8'd0, 2'b01, 8'hFF, 2'b10);
    rexp[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    do_read("t6_mem0", 64'h0, 8'd0, 2'b01, 1'b0, 2'b00);
`else
    rexp[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    do_read("t6_oor_rd", 64'h8000, 8'd0, 2'b01, 1'b0, 2'b00);
    wbuf[0] = 64'hDEAD_BEEF;
    do_write("t6_oor_wr", 64'h8000, 8'd0, 2'b01, 8'hFF, 2'b00);
    rexp[0] = 64'hDEAD_BEEF;
    do_read("t6_mem0", 64'h0, 8'd0, 2'b01, 1'b0, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
